// File: rtl/pipelined_controller_if.sv
// pipelined_controller_if: decode inputs, pipeline control outputs and hazard selects of the RV32I controller.
interface pipelined_controller_if #(parameter int REGADDR_W = 5);
  logic [6:0] op_d;
  logic [2:0] funct3_d;
  logic funct7b5_d, funct7b0_d;
  logic [REGADDR_W-1:0] rs1_d, rs2_d, rd_d;
  logic Zero_e;
  logic [2:0] ImmSrc_d;
  logic illegal_d;
  logic ALUSrcA_e, ALUSrcB_e;
  logic [4:0] ALUControl_e;
  logic PCSrc_e, Jalr_e;
  logic [1:0] ForwardA_e, ForwardB_e;
  logic MemWrite_m;
  logic [1:0] Store_m;
  logic [2:0] Load_m;
  logic RegWrite_w;
  logic [1:0] ResultSrc_w;
  logic StallF, StallD, FlushD, FlushE;
  modport master (
    output op_d, funct3_d, funct7b5_d, funct7b0_d, rs1_d, rs2_d, rd_d, Zero_e,
    input ImmSrc_d, illegal_d, ALUSrcA_e, ALUSrcB_e, ALUControl_e, PCSrc_e, Jalr_e,
    ForwardA_e, ForwardB_e, MemWrite_m, Store_m, Load_m, RegWrite_w, ResultSrc_w,
    StallF, StallD, FlushD, FlushE
  );
  modport slave (
    input op_d, funct3_d, funct7b5_d, funct7b0_d, rs1_d, rs2_d, rd_d, Zero_e,
    output ImmSrc_d, illegal_d, ALUSrcA_e, ALUSrcB_e, ALUControl_e, PCSrc_e, Jalr_e,
    ForwardA_e, ForwardB_e, MemWrite_m, Store_m, Load_m, RegWrite_w, ResultSrc_w,
    StallF, StallD, FlushD, FlushE
  );
endinterface

// File: rtl/pipelined_controller.sv
// pipelined_controller: RV32I decode, D/E/M/W control pipeline, branch resolve, stall/flush/forward.
// Define RV32M_EN to decode the RV32M multiply/divide group.
module pipelined_controller #(parameter int REGADDR_W = 5) (
  input logic clk,
  input logic reset,
  pipelined_controller_if.slave bus
);
  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic branch;
    logic jump;
    logic jalr;
    logic src_a;
    logic src_b;
    logic [1:0] result_src;
    logic [4:0] alu_ctl;
    logic [2:0] funct3;
  } ctrl_t;
  ctrl_t dec, ctrl_e_d, ctrl_e_q;
  logic [REGADDR_W-1:0] rs1_e_q, rs2_e_q, rd_e_q, rd_m_q, rd_w_q;
  logic reg_write_m_q, mem_write_m_q, reg_write_w_q;
  logic [1:0] result_src_m_q, result_src_w_q;
  logic [2:0] funct3_m_q, f3;
  logic [4:0] alu_op;
  logic illegal, r_base, lw_stall, taken, pc_src, flush_e;
  function automatic logic [1:0] fwd(input logic [REGADDR_W-1:0] rs, input logic we_m,
      input logic [REGADDR_W-1:0] rd_m, input logic we_w, input logic [REGADDR_W-1:0] rd_w);
    return (we_m && rd_m != '0 && rd_m == rs) ? 2'b10 :
           (we_w && rd_w != '0 && rd_w == rs) ? 2'b01 : 2'b00;
  endfunction
  assign f3 = bus.funct3_d;
  assign alu_op = f3 == 3'b001 ? 5'b00111 : f3 == 3'b010 ? 5'b00101 : f3 == 3'b011 ? 5'b00110 :
                  f3 == 3'b100 ? 5'b00100 : f3 == 3'b101 ? (bus.funct7b5_d ? 5'b01001 : 5'b01000) :
                  f3 == 3'b110 ? 5'b00011 : f3 == 3'b111 ? 5'b00010 : 5'b00000;
  // funct7b5 is only a legal R-type modifier on add/sub and srl/sra
  assign r_base = ~bus.funct7b0_d & (~bus.funct7b5_d | f3 == 3'b000 | f3 == 3'b101);
  always_comb begin
    dec = '0;
    illegal = 1'b0;
    bus.ImmSrc_d = 3'b000;
    dec.funct3 = f3;
    case (bus.op_d)
      7'b0000011: begin
        dec.reg_write = 1'b1;
        dec.src_b = 1'b1;
        dec.result_src = 2'b01;
        illegal = f3 == 3'b011 || f3[2:1] == 2'b11;
      end
      7'b0010011: begin
        dec.reg_write = 1'b1;
        dec.src_b = 1'b1;
        dec.alu_ctl = alu_op;
        illegal = f3 == 3'b001 && bus.funct7b5_d;
      end
      7'b0010111: begin
        dec.reg_write = 1'b1;
        dec.src_a = 1'b1;
        dec.src_b = 1'b1;
        bus.ImmSrc_d = 3'b011;
      end
      7'b0100011: begin
        dec.mem_write = 1'b1;
        dec.src_b = 1'b1;
        bus.ImmSrc_d = 3'b001;
        illegal = f3[2] | (f3[1] & f3[0]);
      end
      7'b0110011: begin
        dec.reg_write = 1'b1;
        dec.alu_ctl = (f3 == 3'b000 && bus.funct7b5_d) ? 5'b00001 : alu_op;
        illegal = ~r_base;
`ifdef RV32M_EN
        if (bus.funct7b0_d && !bus.funct7b5_d) begin
          dec.alu_ctl = {2'b10, f3};
          illegal = 1'b0;
        end
`endif
      end
      7'b0110111: begin
        dec.reg_write = 1'b1;
        dec.result_src = 2'b11;
        bus.ImmSrc_d = 3'b011;
      end
      7'b1100011: begin
        dec.branch = 1'b1;
        dec.alu_ctl = f3[2] ? (f3[1] ? 5'b00110 : 5'b00101) : 5'b00001;
        bus.ImmSrc_d = 3'b010;
        illegal = f3[2:1] == 2'b01;
      end
      7'b1100111: begin
        dec.reg_write = 1'b1;
        dec.jump = 1'b1;
        dec.jalr = 1'b1;
        dec.src_b = 1'b1;
        dec.result_src = 2'b10;
        illegal = f3 != 3'b000;
      end
      7'b1101111: begin
        dec.reg_write = 1'b1;
        dec.jump = 1'b1;
        dec.src_a = 1'b1;
        dec.src_b = 1'b1;
        dec.result_src = 2'b10;
        bus.ImmSrc_d = 3'b100;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) dec = '0;
  end
  assign lw_stall = ctrl_e_q.result_src == 2'b01 && ctrl_e_q.reg_write && rd_e_q != '0 &&
                    (rd_e_q == bus.rs1_d || rd_e_q == bus.rs2_d);
  // beq/bge/bgeu take on Zero, bne/blt/bltu on !Zero
  assign taken = bus.Zero_e ^ ctrl_e_q.funct3[0] ^ ctrl_e_q.funct3[2];
  assign pc_src = (ctrl_e_q.branch & taken) | ctrl_e_q.jump;
  assign flush_e = lw_stall | pc_src;
  assign ctrl_e_d = flush_e ? '0 : dec;
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_e_q <= '0;
      rs1_e_q <= '0;
      rs2_e_q <= '0;
      rd_e_q <= '0;
      reg_write_m_q <= 1'b0;
      mem_write_m_q <= 1'b0;
      result_src_m_q <= '0;
      funct3_m_q <= '0;
      rd_m_q <= '0;
      reg_write_w_q <= 1'b0;
      result_src_w_q <= '0;
      rd_w_q <= '0;
    end else begin
      ctrl_e_q <= ctrl_e_d;
      rs1_e_q <= flush_e ? '0 : bus.rs1_d;
      rs2_e_q <= flush_e ? '0 : bus.rs2_d;
      rd_e_q <= flush_e ? '0 : bus.rd_d;
      reg_write_m_q <= ctrl_e_q.reg_write;
      mem_write_m_q <= ctrl_e_q.mem_write;
      result_src_m_q <= ctrl_e_q.result_src;
      funct3_m_q <= ctrl_e_q.funct3;
      rd_m_q <= rd_e_q;
      reg_write_w_q <= reg_write_m_q;
      result_src_w_q <= result_src_m_q;
      rd_w_q <= rd_m_q;
    end
  end
  assign bus.illegal_d = illegal;
  assign bus.ALUSrcA_e = ctrl_e_q.src_a;
  assign bus.ALUSrcB_e = ctrl_e_q.src_b;
  assign bus.ALUControl_e = ctrl_e_q.alu_ctl;
  assign bus.PCSrc_e = pc_src;
  assign bus.Jalr_e = ctrl_e_q.jalr;
  assign bus.ForwardA_e = fwd(rs1_e_q, reg_write_m_q, rd_m_q, reg_write_w_q, rd_w_q);
  assign bus.ForwardB_e = fwd(rs2_e_q, reg_write_m_q, rd_m_q, reg_write_w_q, rd_w_q);
  assign bus.MemWrite_m = mem_write_m_q;
  assign bus.Store_m = funct3_m_q[1:0];
  assign bus.Load_m = funct3_m_q;
  assign bus.RegWrite_w = reg_write_w_q;
  assign bus.ResultSrc_w = result_src_w_q;
  assign bus.StallF = lw_stall;
  assign bus.StallD = lw_stall;
  assign bus.FlushD = pc_src;
  assign bus.FlushE = flush_e;
endmodule

// File: tb/tb_pipelined_controller.sv
// tb_pipelined_controller: directed instruction stream; expectations queued per cycle, checked by a negedge monitor.
module tb_pipelined_controller;
  localparam logic [6:0] OP_LD = 7'b0000011, OP_I = 7'b0010011, OP_ST = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JALR = 7'b1100111, OP_JAL = 7'b1101111;
  localparam int IMM = 0, ILL = 1, SRCA = 2, SRCB = 3, ALUC = 4, PCS = 5, JLR = 6, FWA = 7, FWB = 8;
  localparam int MW = 9, STO = 10, LDM = 11, RW = 12, RS = 13, STF = 14, STD = 15, FLD = 16, FLE = 17;
  typedef struct {
    int cyc;
    int sel;
    logic [7:0] v;
  } exp_t;
  exp_t q[$];
  logic clk = 1'b0;
  logic reset;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  pipelined_controller_if #(.REGADDR_W(5)) bus ();
  pipelined_controller #(.REGADDR_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] get(input int s);
    case (s)
      IMM: return 8'(bus.ImmSrc_d);
      ILL: return 8'(bus.illegal_d);
      SRCA: return 8'(bus.ALUSrcA_e);
      SRCB: return 8'(bus.ALUSrcB_e);
      ALUC: return 8'(bus.ALUControl_e);
      PCS: return 8'(bus.PCSrc_e);
      JLR: return 8'(bus.Jalr_e);
      FWA: return 8'(bus.ForwardA_e);
      FWB: return 8'(bus.ForwardB_e);
      MW: return 8'(bus.MemWrite_m);
      STO: return 8'(bus.Store_m);
      LDM: return 8'(bus.Load_m);
      RW: return 8'(bus.RegWrite_w);
      RS: return 8'(bus.ResultSrc_w);
      STF: return 8'(bus.StallF);
      STD: return 8'(bus.StallD);
      FLD: return 8'(bus.FlushD);
      default: return 8'(bus.FlushE);
    endcase
  endfunction
  function automatic string nm(input int s);
    case (s)
      IMM: return "ImmSrc_d";
      ILL: return "illegal_d";
      SRCA: return "ALUSrcA_e";
      SRCB: return "ALUSrcB_e";
      ALUC: return "ALUControl_e";
      PCS: return "PCSrc_e";
      JLR: return "Jalr_e";
      FWA: return "ForwardA_e";
      FWB: return "ForwardB_e";
      MW: return "MemWrite_m";
      STO: return "Store_m";
      LDM: return "Load_m";
      RW: return "RegWrite_w";
      RS: return "ResultSrc_w";
      STF: return "StallF";
      STD: return "StallD";
      FLD: return "FlushD";
      default: return "FlushE";
    endcase
  endfunction
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        total++;
        if (get(q[i].sel) !== q[i].v) begin
          bad++;
          $display("FAIL %s cycle %0d: got %0h expected %0h", nm(q[i].sel), cyc, get(q[i].sel), q[i].v);
        end
        q.delete(i);
      end
    end
  end
  task automatic exp(input int dly, input int sel, input logic [7:0] v);
    q.push_back('{cyc + dly, sel, v});
  endtask
  task automatic drv(input logic [6:0] op, input logic [2:0] f3, input logic b5, input logic b0,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    bus.op_d = op;
    bus.funct3_d = f3;
    bus.funct7b5_d = b5;
    bus.funct7b0_d = b0;
    bus.rs1_d = r1;
    bus.rs2_d = r2;
    bus.rd_d = rd;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      drv(OP_I, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      step();
    end
  endtask
  initial begin
    reset = 1'b1;
    bus.Zero_e = 1'b0;
    drv(7'b0, 3'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step();
    total++;
    if (bus.illegal_d !== 1'b1) begin
      bad++;
      $display("FAIL illegal_d after reset: got %0b", bus.illegal_d);
    end
    total++;
    if (bus.ForwardA_e !== 2'b00) begin
      bad++;
      $display("FAIL ForwardA_e after reset: got %0b", bus.ForwardA_e);
    end
    exp(0, ILL, 1); exp(0, ALUC, 0); exp(0, PCS, 0); exp(0, MW, 0); exp(0, RW, 0);
    exp(0, FWA, 0); exp(0, FWB, 0); exp(0, STF, 0); exp(0, FLD, 0); exp(0, FLE, 0);
    reset = 1'b0;
    step();
    drv(OP_R, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
    exp(0, ILL, 0); exp(1, ALUC, 0); exp(1, SRCB, 0); exp(3, RW, 1); exp(3, RS, 0);
    step();
    nops(3);
    drv(OP_LD, 3'b010, 1'b0, 1'b0, 5'd1, 5'd0, 5'd5);
    exp(0, ILL, 0); exp(0, IMM, 0); exp(1, SRCB, 1); exp(2, LDM, 2); exp(3, RS, 1); exp(3, RW, 1);
    step();
    drv(OP_R, 3'b000, 1'b0, 1'b0, 5'd5, 5'd2, 5'd6);
    exp(0, STF, 1); exp(0, STD, 1); exp(0, FLE, 1); exp(0, FLD, 0); exp(3, RW, 0);
    step();
    exp(0, STF, 0); exp(0, FLE, 0); exp(1, FWA, 1); exp(1, FWB, 0); exp(3, RW, 1);
    step();
    nops(3);
    drv(OP_I, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7);
    step();
    drv(OP_I, 3'b000, 1'b1, 1'b0, 5'd7, 5'd0, 5'd8);
    exp(1, FWA, 2); exp(1, ALUC, 0);
    step();
    nops(1);
    drv(OP_I, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7);
    step();
    nops(1);
    drv(OP_I, 3'b000, 1'b0, 1'b0, 5'd7, 5'd0, 5'd8);
    exp(1, FWA, 1);
    step();
    drv(OP_I, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step();
    drv(OP_I, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8);
    exp(1, FWA, 0); exp(1, FWB, 0);
    step();
    drv(OP_I, 3'b101, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0); exp(1, ALUC, 9); step();
    drv(OP_R, 3'b000, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0); exp(1, ALUC, 1); step();
    drv(OP_R, 3'b101, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0); exp(1, ALUC, 9); step();
    drv(OP_R, 3'b110, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0); exp(1, ALUC, 3); step();
    drv(OP_R, 3'b001, 1'b1, 1'b0, 5'd0, 5'd0, 5'd4); exp(0, ILL, 1); exp(3, RW, 0); step();
    nops(3);
    drv(OP_BR, 3'b000, 1'b0, 1'b0, 5'd9, 5'd10, 5'd0);
    exp(0, IMM, 2); exp(1, PCS, 1); exp(1, FLD, 1); exp(1, FLE, 1); exp(1, ALUC, 1);
    step();
    bus.Zero_e = 1'b1;
    nops(1);
    drv(OP_BR, 3'b001, 1'b0, 1'b0, 5'd9, 5'd10, 5'd0);
    exp(1, PCS, 0); exp(1, FLD, 0); exp(1, FLE, 0);
    step();
    nops(1);
    bus.Zero_e = 1'b0;
    drv(OP_BR, 3'b100, 1'b0, 1'b0, 5'd9, 5'd10, 5'd0);
    exp(1, PCS, 1); exp(1, ALUC, 5);
    step();
    nops(1);
    drv(OP_BR, 3'b111, 1'b0, 1'b0, 5'd9, 5'd10, 5'd0);
    exp(1, PCS, 0); exp(1, ALUC, 6);
    step();
    nops(1);
    drv(OP_JALR, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd1);
    exp(0, IMM, 0); exp(1, JLR, 1); exp(1, PCS, 1); exp(1, SRCB, 1); exp(3, RS, 2); exp(3, RW, 1);
    step();
    nops(3);
    drv(OP_R, 3'b100, 1'b0, 1'b1, 5'd0, 5'd0, 5'd4);
`ifdef RV32M_EN
    exp(0, ILL, 0); exp(1, ALUC, 8'h14); exp(3, RW, 1);
`else
    exp(0, ILL, 1); exp(1, ALUC, 0); exp(3, RW, 0);
`endif
    step();
    nops(3);
    drv(OP_ST, 3'b010, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0);
    exp(0, IMM, 1); exp(2, MW, 1); exp(2, STO, 2);
    step();
    drv(OP_JAL, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd1);
    exp(0, IMM, 4); exp(1, PCS, 1); exp(1, SRCA, 1);
    step();
    reset = 1'b1;
    nops(1);
    reset = 1'b0;
    drv(OP_I, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    total++;
    if (bus.MemWrite_m !== 1'b0) begin
      bad++;
      $display("FAIL MemWrite_m after mid-stream reset: got %0b", bus.MemWrite_m);
    end
    total++;
    if (bus.PCSrc_e !== 1'b0) begin
      bad++;
      $display("FAIL PCSrc_e after mid-stream reset: got %0b", bus.PCSrc_e);
    end
    total++;
    if (bus.RegWrite_w !== 1'b0) begin
      bad++;
      $display("FAIL RegWrite_w after mid-stream reset: got %0b", bus.RegWrite_w);
    end
    exp(0, MW, 0); exp(0, PCS, 0); exp(0, SRCA, 0); exp(0, ALUC, 0); exp(0, JLR, 0);
    exp(0, FWA, 0); exp(0, FLD, 0); exp(0, FLE, 0); exp(0, STF, 0); exp(1, RW, 0); exp(1, RS, 0);
    step();
    nops(3);
    foreach (q[i]) begin
      total++;
      bad++;
      $display("FAIL %s expired: scheduled cycle %0d never checked, expected %0h", nm(q[i].sel), q[i].cyc, q[i].v);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
